// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if #(
    parameter int unsigned DPW = 32,
    parameter int unsigned ADW = 32
);
    logic           imem_req_valid;
    logic [ADW-1:0] imem_req_addr;
    logic           imem_req_ready;
    logic           imem_rsp_valid;
    logic [DPW-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// rv32i fetch front end: owns the PC, issues credit-limited imem requests,
// queues returned words in order and drops responses made stale by a redirect.
module fetch_stage #(
    parameter int unsigned    DPW      = 32,
    parameter int unsigned    ADW      = 32,
    parameter logic [DPW-1:0] RESET_PC = '0,
    parameter int unsigned    QDEPTH   = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stallF,
    input  logic           PCSrcE,
    input  logic [DPW-1:0] PCTargetE,
    fetch_stage_if.master  imem,
    output logic [DPW-1:0] instrF,
    output logic           validF,
    output logic [DPW-1:0] PCF,
    output logic [DPW-1:0] PCPlus4F
);
    localparam int unsigned    CW  = $clog2(QDEPTH + 1);
    localparam int unsigned    QW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [DPW-1:0] NOP = DPW'(32'h0000_0013);

    logic [DPW-1:0] r_fpc;
    logic [DPW-1:0] r_pcf;
    logic [DPW-1:0] r_q [QDEPTH];
    logic [QW-1:0]  r_rd;
    logic [QW-1:0]  r_wr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_outst;
    logic [CW-1:0]  r_drop;

    logic [DPW-1:0] w_tgt;
    logic [CW:0]    w_inflight;
    logic           w_req_valid;
    logic           w_fire;
    logic           w_rsp;
    logic           w_push;
    logic           w_pop;

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        return (p == QW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_tgt       = PCTargetE & ~DPW'(3);
        // In-flight plus buffered words never exceed the queue, so every push has room.
        w_inflight  = {1'b0, r_outst} + {1'b0, r_count};
        w_req_valid = !rst && !PCSrcE && (w_inflight < (CW+1)'(QDEPTH));
        w_fire      = w_req_valid && imem.imem_req_ready;
        w_rsp       = imem.imem_rsp_valid;
        validF      = (r_count != '0);
        w_push      = w_rsp && (r_drop == '0) && !PCSrcE;
        w_pop       = validF && !stallF && !PCSrcE;
        instrF      = validF ? r_q[r_rd] : NOP;
        PCF         = r_pcf;
        PCPlus4F    = r_pcf + DPW'(4);
        imem.imem_req_valid = w_req_valid;
        imem.imem_req_addr  = r_fpc[ADW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc   <= RESET_PC;
            r_pcf   <= RESET_PC;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_outst <= '0;
            r_drop  <= '0;
        end else if (PCSrcE) begin
            // Everything still in flight, minus a response landing now, is stale.
            r_fpc   <= w_tgt;
            r_pcf   <= w_tgt;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_outst <= r_outst - CW'(w_rsp);
            r_drop  <= r_outst - CW'(w_rsp);
        end else begin
            if (w_fire) begin
                r_fpc <= r_fpc + DPW'(4);
            end
            r_outst <= r_outst + CW'(w_fire) - CW'(w_rsp);
            if (w_rsp && (r_drop != '0)) begin
                r_drop <= r_drop - 1'b1;
            end
            if (w_push) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (w_pop) begin
                r_rd  <= ptr_inc(r_rd);
                r_pcf <= r_pcf + DPW'(4);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_q[r_wr] <= imem.imem_rsp_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_count == CW'(QDEPTH))));
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, redirect/stall sequences,
// randomized traffic against a queue-based reference model, and a PC-wrap instance.
module tb_fetch_stage;
    localparam logic [31:0] RST_PC  = 32'h0000_0100;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          QD      = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, stallF = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic [31:0] instrF, PCF, PCPlus4F;
    logic        validF;

    fetch_stage_if #(.DPW(32), .ADW(32)) m_if ();

    fetch_stage #(.DPW(32), .ADW(32), .RESET_PC(RST_PC), .QDEPTH(QD)) u_dut (
        .clk(clk), .rst(rst), .stallF(stallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem(m_if), .instrF(instrF), .validF(validF), .PCF(PCF), .PCPlus4F(PCPlus4F)
    );

    logic        w_rst = 1'b1;
    logic [31:0] w_instrF, w_PCF, w_PCPlus4F;
    logic        w_validF;

    fetch_stage_if #(.DPW(32), .ADW(32)) w_if ();

    fetch_stage #(.DPW(32), .ADW(32), .RESET_PC(WRAP_PC), .QDEPTH(QD)) u_wrap (
        .clk(clk), .rst(w_rst), .stallF(1'b0), .PCSrcE(1'b0), .PCTargetE(32'h0),
        .imem(w_if), .instrF(w_instrF), .validF(w_validF), .PCF(w_PCF), .PCPlus4F(w_PCPlus4F)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;

    // Memory: in-order pending requests, each due a fixed latency after acceptance.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       mem_q[$];
    int          mem_lat = 1;
    logic [31:0] mem_xor = '0;

    // Reference model: architectural view using a word queue and plain counters.
    bit          m_on = 1'b0;
    logic [31:0] m_pcf = '0, m_fpc = '0;
    logic [31:0] m_q[$];
    int          m_out = 0, m_drop = 0;

    logic        s_reqv, s_validF, s_rsp;
    logic [31:0] s_addr, s_instr, s_pcf, s_p4;

    typedef struct {
        logic rst, stall, pcsrc, ready;
        logic [31:0] tgt;
        logic reqv; logic [31:0] addr;
        logic chk; logic validF; logic [31:0] instr, pcf;
    } vec_t;
    vec_t vt[9];

    function automatic vec_t mk(input logic r, input logic rq, input logic [31:0] a,
                                input logic c, input logic v, input logic [31:0] ins,
                                input logic [31:0] pc);
        vec_t x;
        x.rst = r; x.stall = 1'b0; x.pcsrc = 1'b0; x.ready = 1'b1; x.tgt = '0;
        x.reqv = rq; x.addr = a; x.chk = c; x.validF = v; x.instr = ins; x.pcf = pc;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One cycle, entered and left at negedge: drive, sample, compare, advance.
    task automatic tick(input logic t_rst, input logic t_stall, input logic t_pcsrc,
                        input logic t_ready, input logic [31:0] t_tgt);
        logic        exp_reqv, fired;
        logic [31:0] faddr, rsp_d;
        int          d;
        rst = t_rst; stallF = t_stall; PCSrcE = t_pcsrc; PCTargetE = t_tgt;
        m_if.imem_req_ready = t_ready;
        if (!t_rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m_if.imem_rsp_valid = 1'b1;
            m_if.imem_rsp_data  = mem_q[0].addr ^ mem_xor;
            void'(mem_q.pop_front());
        end else begin
            m_if.imem_rsp_valid = 1'b0;
            m_if.imem_rsp_data  = $urandom;
        end
        s_rsp = m_if.imem_rsp_valid;
        rsp_d = m_if.imem_rsp_data;
        #1;
        s_reqv = m_if.imem_req_valid; s_addr = m_if.imem_req_addr;
        s_validF = validF; s_instr = instrF; s_pcf = PCF; s_p4 = PCPlus4F;
        exp_reqv = !t_rst && !t_pcsrc && ((m_out + m_q.size()) < QD);
        if (m_on) begin
            chk("m_req_valid", s_reqv, exp_reqv);
            chk("m_req_addr", s_addr, m_fpc);
            chk("m_validF", s_validF, m_q.size() > 0);
            chk("m_instrF", s_instr, (m_q.size() > 0) ? m_q[0] : NOP);
            chk("m_PCF", s_pcf, m_pcf);
            chk("m_PCPlus4F", s_p4, m_pcf + 32'd4);
        end
        fired = s_reqv && t_ready;
        faddr = s_addr;
        if (t_rst) begin
            m_pcf = RST_PC; m_fpc = RST_PC; m_q.delete(); m_out = 0; m_drop = 0;
        end else if (t_pcsrc) begin
            m_pcf = t_tgt & ~32'd3; m_fpc = t_tgt & ~32'd3; m_q.delete();
            m_out = m_out - int'(s_rsp); m_drop = m_out;
        end else begin
            if (exp_reqv && t_ready) begin m_fpc = m_fpc + 32'd4; m_out++; end
            if (m_q.size() > 0 && !t_stall) begin void'(m_q.pop_front()); m_pcf = m_pcf + 32'd4; end
            if (s_rsp) begin
                m_out--;
                if (m_drop > 0) m_drop--;
                else m_q.push_back(rsp_d);
            end
        end
        @(posedge clk);
        if (t_rst) begin
            mem_q.delete();
            m_on = 1'b1;
        end else if (fired) begin
            d = cyc + mem_lat;
            if (mem_q.size() > 0 && mem_q[$].due >= d) d = mem_q[$].due + 1;
            mem_q.push_back('{faddr, d});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (m_q.size() == 0 && m_out == 0 && mem_q.size() == 0) done = 1'b1;
            else tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        chk(nm, done, 1'b1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit          found;
        bit          w_pend;
        logic [31:0] w_pa;
        int          seen;
        m_if.imem_req_ready = 1'b0; m_if.imem_rsp_valid = 1'b0; m_if.imem_rsp_data = '0;
        w_if.imem_req_ready = 1'b1; w_if.imem_rsp_valid = 1'b0; w_if.imem_rsp_data = '0;

        // Reset then streaming with a 1-cycle memory returning addr as data.
        vt[0] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0);
        vt[1] = mk(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, NOP,     32'h100);
        vt[2] = mk(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, NOP,     32'h100);
        vt[3] = mk(1'b0, 1'b1, 32'h104, 1'b1, 1'b0, NOP,     32'h100);
        vt[4] = mk(1'b0, 1'b0, 32'h108, 1'b1, 1'b1, 32'h100, 32'h100);
        vt[5] = mk(1'b0, 1'b1, 32'h108, 1'b1, 1'b1, 32'h104, 32'h104);
        vt[6] = mk(1'b0, 1'b1, 32'h10C, 1'b1, 1'b0, NOP,     32'h108);
        vt[7] = mk(1'b0, 1'b0, 32'h110, 1'b1, 1'b1, 32'h108, 32'h108);
        vt[8] = mk(1'b0, 1'b1, 32'h110, 1'b1, 1'b1, 32'h10C, 32'h10C);

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            tick(vt[i].rst, vt[i].stall, vt[i].pcsrc, vt[i].ready, vt[i].tgt);
            chk($sformatf("tbl%0d_reqv", i), s_reqv, vt[i].reqv);
            if (vt[i].chk) begin
                chk($sformatf("tbl%0d_addr", i), s_addr, vt[i].addr);
                chk($sformatf("tbl%0d_validF", i), s_validF, vt[i].validF);
                chk($sformatf("tbl%0d_instrF", i), s_instr, vt[i].instr);
                chk($sformatf("tbl%0d_PCF", i), s_pcf, vt[i].pcf);
            end
        end

        // Stall for 5 cycles: queue fills, requests stop, head frozen.
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
            if (i >= 1) begin
                chk("stall_instrF", s_instr, 32'h110);
                chk("stall_PCF", s_pcf, 32'h110);
                chk("stall_reqv", s_reqv, 1'b0);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("unstall_instr0", s_instr, 32'h110);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("unstall_instr1", s_instr, 32'h114);
        chk("unstall_PCF1", s_pcf, 32'h114);

        // Redirect with two requests in flight on a 3-cycle memory.
        drain("drain_r4");
        mem_lat = 3;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 32'h403);
        chk("r4_reqv_in_redirect", s_reqv, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("r4_PCF", s_pcf, 32'h400);
        chk("r4_validF", s_validF, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            if (s_validF) found = 1'b1;
        end
        chk("r4_found", found, 1'b1);
        chk("r4_instrF", s_instr, 32'h400);
        chk("r4_PCF_head", s_pcf, 32'h400);

        // Redirect landing on the same cycle as the only outstanding response.
        drain("drain_r5");
        mem_lat = 2;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h800);
        chk("r5_rsp_same_cycle", s_rsp, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            if (s_validF) found = 1'b1;
        end
        chk("r5_found", found, 1'b1);
        chk("r5_instrF", s_instr, 32'h800);
        chk("r5_PCF", s_pcf, 32'h800);

        // Randomized traffic against the model.
        mem_xor = 32'hA5A5_0000;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) mem_lat = int'($urandom_range(1, 4));
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 70, $urandom);
        end

        // PC wrap on a second instance reset to 0xFFFF_FFFC, 1-cycle memory.
        @(posedge clk); @(negedge clk);
        w_rst = 1'b0;
        w_pend = 1'b0; w_pa = '0; seen = 0;
        for (int i = 0; i < 8; i++) begin
            w_if.imem_rsp_valid = w_pend;
            w_if.imem_rsp_data  = w_pa;
            #1;
            if (i == 0) chk("wrap_addr0", w_if.imem_req_addr, WRAP_PC);
            if (w_validF && seen == 0) begin
                chk("wrap_PCF0", w_PCF, WRAP_PC);
                chk("wrap_PCPlus4F0", w_PCPlus4F, 32'h0);
                chk("wrap_instr0", w_instrF, WRAP_PC);
                seen = 1;
            end else if (w_validF && seen == 1) begin
                chk("wrap_PCF1", w_PCF, 32'h0);
                chk("wrap_instr1", w_instrF, 32'h0);
                seen = 2;
            end
            w_pend = w_if.imem_req_valid && w_if.imem_req_ready;
            w_pa   = w_if.imem_req_addr;
            @(posedge clk); @(negedge clk);
        end
        chk("wrap_seen", seen, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
